// File: rtl/reduce_gate_acc_if.sv
// reduce_gate_acc_if: beat input / frame result handshake bundle for reduce_gate_acc.
// REDUCE_GATE_ONESCNT_EN adds the ones_cnt result field.
interface reduce_gate_acc_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_data;
    logic [CNT_W-1:0] out_beats;
`ifdef REDUCE_GATE_ONESCNT_EN
    logic [CNT_W+6:0] ones_cnt;
    modport slave (input in_valid, in_data, in_last, mode, out_ready,
                   output in_ready, out_valid, out_data, out_beats, ones_cnt);
    modport master (output in_valid, in_data, in_last, mode, out_ready,
                    input in_ready, out_valid, out_data, out_beats, ones_cnt);
`else
    modport slave (input in_valid, in_data, in_last, mode, out_ready,
                   output in_ready, out_valid, out_data, out_beats);
    modport master (output in_valid, in_data, in_last, mode, out_ready,
                    input in_ready, out_valid, out_data, out_beats);
`endif
endinterface

// File: rtl/reduce_gate_acc.sv
// reduce_gate_acc: folds multi-beat frames into one wide AND/OR/XOR (optionally inverted) gate.
// REDUCE_GATE_ONESCNT_EN adds a saturating per-frame count of 1 bits.
module reduce_gate_acc #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    reduce_gate_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d, sel_mode;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, first, op_and, op_or, beat_red, folded;
    assign accept   = bus.in_valid && bus.in_ready;
    assign first    = state_q == IDLE;
    // the first beat uses the live mode, later beats the latched one
    assign sel_mode = first ? bus.mode : mode_q;
    assign op_and   = sel_mode == 3'd0 || sel_mode == 3'd3;
    assign op_or    = sel_mode == 3'd1 || sel_mode == 3'd4;
    assign beat_red = op_and ? &bus.in_data : op_or ? |bus.in_data : ^bus.in_data;
    assign folded   = op_and ? acc_q & beat_red : op_or ? acc_q | beat_red : acc_q ^ beat_red;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bus.in_last ? HOLD : ACC) : IDLE;
            ACC:     state_d = accept && bus.in_last ? HOLD : ACC;
            HOLD:    state_d = bus.out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.in_ready  = state_q != HOLD;
        bus.out_valid = state_q == HOLD;
        bus.out_data  = acc_q ^ (mode_q >= 3'd3);
        bus.out_beats = cnt_q;
    end
    always_comb begin
        mode_d = accept && first ? bus.mode : mode_q;
        acc_d  = accept ? (first ? beat_red : folded) : acc_q;
        cnt_d  = accept ? (first ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1))) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            acc_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end
`ifdef REDUCE_GATE_ONESCNT_EN
    logic [CNT_W+6:0] ones_q, ones_d, pc;
    logic [CNT_W+7:0] ones_sum;
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + {{(CNT_W+6){1'b0}}, bus.in_data[i]};
        ones_sum = {1'b0, first ? {(CNT_W+7){1'b0}} : ones_q} + {1'b0, pc};
        ones_d   = accept ? (ones_sum[CNT_W+7] ? {(CNT_W+7){1'b1}} : ones_sum[CNT_W+6:0]) : ones_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ones_q <= '0;
        else        ones_q <= ones_d;
    end
    assign bus.ones_cnt = ones_q;
`endif
endmodule
